hdmi_line_prefetch: RTL

- Scheduler that feeds the HDMI test-card/PPU colour path from a framebuffer in memory.
- Watches the pixel cursor and sequences word reads of the next source row into a ping-pong line buffer during the current row's display time.
- Returns the colour for the current cursor position; upscales the source image by 2^SCALE_SHIFT in both axes.
- Lives in the pixel clock domain, between the timing/test-card logic and the memory read port.

---
 rtl/hdmi_line_prefetch.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_line_prefetch.sv
`default_nettype none
// ============================================================================
//  Module   : hdmi_line_prefetch
//  Purpose  : Pixel-clock-domain scheduler that prefetches the next source row
//             of a framebuffer into a ping-pong line buffer while the current
//             row is on screen. It returns the colour under the pixel cursor,
//             upscaled by 2^SCALE_SHIFT in both axes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   pixel clock
//    reset          in   1   synchronous, active-high
//    enable         in   1   allows new fetch triggers and the display path
//    fb_base        in  32   framebuffer word base, sampled at frame trigger
//    xcursor        in  14   current pixel x
//    ycursor        in  14   current pixel y
//    ppu_color      out 24   colour for the cursor, one cycle of latency
//    mem_req_valid  out  1   read request valid
//    mem_req_ready  in   1   read request accepted
//    mem_req_addr   out 32   read word address
//    mem_rsp_valid  in   1   read data valid (responses arrive in order)
//    mem_rsp_data   in  24   RGB888 read data
//    busy           out  1   row fetch in progress
//    underrun       out  1   sticky error flag, cleared only by reset
//    underrun_count out 16   saturating count of underrun events
//                            (present only with HDMI_PREFETCH_UNDERRUN_CNT_EN)
//  Build option
//    HDMI_PREFETCH_UNDERRUN_CNT_EN : adds the underrun_count output.
// ============================================================================
module hdmi_line_prefetch #(
   parameter int H_ACTIVE        = 1280,
   parameter int V_ACTIVE        = 720,
   parameter int V_TOTAL         = 750,
   parameter int SCALE_SHIFT     = 2,
   parameter int SRC_W           = 320,
   parameter int SRC_H           = 180,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] fb_base,
   input  logic [13:0] xcursor,
   input  logic [13:0] ycursor,
   output logic [23:0] ppu_color,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [23:0] mem_rsp_data,
   output logic        busy,
   output logic        underrun
`ifdef HDMI_PREFETCH_UNDERRUN_CNT_EN
   ,
   output logic [15:0] underrun_count
`endif
);

   // -------------------------------------------------------------------------
   // Derived widths and constants
   // -------------------------------------------------------------------------
   localparam int c_AW = (SRC_W > 1) ? $clog2(SRC_W) : 1;        // buffer address
   localparam int c_CW = $clog2(SRC_W + 1);                      // 0..SRC_W counters
   localparam int c_RW = (SRC_H > 1) ? $clog2(SRC_H) : 1;        // source row index
   localparam int c_OW = $clog2(MAX_OUTSTANDING + 1);            // 0..MAX_OUTSTANDING

   localparam logic [13:0]     c_Y_MASK  = 14'((1 << SCALE_SHIFT) - 1);
   localparam logic [c_CW-1:0] c_SRC_W   = c_CW'(SRC_W);
   localparam logic [c_OW-1:0] c_MAX_OUT = c_OW'(MAX_OUTSTANDING);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_REQ   = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [1:0]      state_q,   state_d;
   logic [31:0]     base_q,    base_d;
   logic [c_RW-1:0] row_q,     row_d;
   logic [c_CW-1:0] req_cnt_q, req_cnt_d;
   logic [c_CW-1:0] rsp_cnt_q, rsp_cnt_d;
   logic [c_OW-1:0] outst_q,   outst_d;
   logic [1:0]      ready_q,   ready_d;     // row_ready per bank
   logic            underrun_q, underrun_d;
   logic [23:0]     color_q;

   // Line buffer: one array per bank, selected by source row bit 0.
   logic [23:0] bank0_mem [SRC_W];
   logic [23:0] bank1_mem [SRC_W];

   // -------------------------------------------------------------------------
   // Cursor decode and fetch triggers
   // -------------------------------------------------------------------------
   logic            w_x_zero;
   logic            w_y_active;
   logic            w_active;
   logic [13:0]     w_src_row;
   logic [13:0]     w_src_row_next;
   logic            w_frame_trig;
   logic            w_row_trig;
   logic            w_trig;
   logic [c_RW-1:0] w_target_row;

   assign w_x_zero       = (xcursor == 14'd0);
   assign w_y_active     = (ycursor < 14'(V_ACTIVE));
   assign w_active       = (xcursor < 14'(H_ACTIVE)) && w_y_active;
   assign w_src_row      = ycursor >> SCALE_SHIFT;
   assign w_src_row_next = w_src_row + 14'd1;

   // The frame trigger fires on the first vblank line; the V_TOTAL bound keeps
   // an out-of-range cursor from being mistaken for it.
   assign w_frame_trig = enable && w_x_zero && (ycursor == 14'(V_ACTIVE))
                       && (ycursor < 14'(V_TOTAL));

   // A row trigger fires on the first display line of each source row and
   // fetches the following source row, if there is one.
   assign w_row_trig = enable && w_x_zero && w_y_active
                     && ((ycursor & c_Y_MASK) == 14'd0)
                     && (w_src_row_next < 14'(SRC_H));

   assign w_trig       = w_frame_trig || w_row_trig;
   assign w_target_row = w_frame_trig ? '0 : c_RW'(w_src_row_next);

   // -------------------------------------------------------------------------
   // Memory request / response handshakes
   // -------------------------------------------------------------------------
   logic w_busy;
   logic w_req_fire;
   logic w_rsp_fire;

   assign w_busy        = (state_q != c_IDLE);
   assign mem_req_valid = (state_q == c_REQ) && (req_cnt_q < c_SRC_W)
                        && (outst_q < c_MAX_OUT);
   assign mem_req_addr  = base_q + (32'(row_q) * 32'(SRC_W)) + 32'(req_cnt_q);
   assign w_req_fire    = mem_req_valid && mem_req_ready;
   assign w_rsp_fire    = mem_rsp_valid && w_busy && (rsp_cnt_q < c_SRC_W);

   // -------------------------------------------------------------------------
   // Underrun events: a trigger arriving while a fetch is still running, or an
   // active line starting on a bank that has not been completely filled.
   // -------------------------------------------------------------------------
   logic w_drop_evt;
   logic w_disp_evt;
   logic w_under_evt;

   assign w_drop_evt  = w_trig && w_busy;
   assign w_disp_evt  = enable && w_x_zero && w_y_active && !ready_q[ycursor[SCALE_SHIFT]];
   assign w_under_evt = w_drop_evt || w_disp_evt;

   // -------------------------------------------------------------------------
   // Fetch sequencer
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      row_d      = row_q;
      req_cnt_d  = req_cnt_q;
      rsp_cnt_d  = rsp_cnt_q;
      outst_d    = outst_q;
      ready_d    = ready_q;
      underrun_d = underrun_q || w_under_evt;

      if (w_req_fire) begin
         req_cnt_d = req_cnt_q + c_CW'(1);
      end
      if (w_rsp_fire) begin
         rsp_cnt_d = rsp_cnt_q + c_CW'(1);
      end

      // A simultaneous accept and response cancel out.
      case ({w_req_fire, w_rsp_fire})
         2'b10:   outst_d = outst_q + c_OW'(1);
         2'b01:   outst_d = outst_q - c_OW'(1);
         default: outst_d = outst_q;
      endcase

      case (state_q)
         c_IDLE: begin
            if (w_trig) begin
               state_d                 = c_REQ;
               row_d                   = w_target_row;
               req_cnt_d               = '0;
               rsp_cnt_d               = '0;
               outst_d                 = '0;
               ready_d[w_target_row[0]] = 1'b0;
               if (w_frame_trig) begin
                  base_d = fb_base;
               end
            end
         end
         c_REQ, c_DRAIN: begin
            // Triggers seen here are dropped (flagged through w_drop_evt).
            if ((req_cnt_d == c_SRC_W) && (rsp_cnt_d == c_SRC_W)) begin
               state_d           = c_IDLE;
               ready_d[row_q[0]] = 1'b1;
            end else if ((state_q == c_REQ) && (req_cnt_d == c_SRC_W)) begin
               state_d = c_DRAIN;
            end
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= c_IDLE;
         base_q     <= '0;
         row_q      <= '0;
         req_cnt_q  <= '0;
         rsp_cnt_q  <= '0;
         outst_q    <= '0;
         ready_q    <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         row_q      <= row_d;
         req_cnt_q  <= req_cnt_d;
         rsp_cnt_q  <= rsp_cnt_d;
         outst_q    <= outst_d;
         ready_q    <= ready_d;
         underrun_q <= underrun_d;
      end
   end

   // -------------------------------------------------------------------------
   // Line buffer write port. The storage itself is not reset: row_ready
   // already tells the display whether a bank holds valid data.
   // -------------------------------------------------------------------------
   logic [c_AW-1:0] w_wr_addr;
   assign w_wr_addr = c_AW'(rsp_cnt_q);

   always_ff @(posedge clk) begin
      if (!reset && w_rsp_fire) begin
         if (row_q[0]) begin
            bank1_mem[w_wr_addr] <= mem_rsp_data;
         end else begin
            bank0_mem[w_wr_addr] <= mem_rsp_data;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Display read port: registered, one cycle behind the cursor. In correct
   // operation the fetch always targets the other bank, so no bypass exists.
   // -------------------------------------------------------------------------
   logic [c_AW-1:0] w_rd_addr;
   logic            w_rd_bank;
   logic [13:0]     w_src_col;

   assign w_src_col = xcursor >> SCALE_SHIFT;
   assign w_rd_addr = c_AW'(w_src_col);
   assign w_rd_bank = ycursor[SCALE_SHIFT];

   always_ff @(posedge clk) begin
      if (reset) begin
         color_q <= '0;
      end else if (w_active && enable) begin
         color_q <= w_rd_bank ? bank1_mem[w_rd_addr] : bank0_mem[w_rd_addr];
      end else begin
         color_q <= '0;
      end
   end

   assign ppu_color = color_q;
   assign busy      = w_busy;
   assign underrun  = underrun_q;

`ifdef HDMI_PREFETCH_UNDERRUN_CNT_EN
   // -------------------------------------------------------------------------
   // Saturating underrun event counter; counts every cycle that raises an
   // underrun event, even when the sticky flag is already set.
   // -------------------------------------------------------------------------
   logic [15:0] ucnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ucnt_q <= '0;
      end else if (w_under_evt && (ucnt_q != 16'hFFFF)) begin
         ucnt_q <= ucnt_q + 16'd1;
      end
   end

   assign underrun_count = ucnt_q;
`endif

endmodule
`default_nettype wire
